// File: rtl/char_term_writer_if.sv
// Byte-stream handshake and character-buffer write port of char_term_writer.
interface char_term_writer_if;
   logic        in_valid;
   logic [7:0]  in_char;
   logic        in_ready;
   logic [11:0] buf_addr;
   logic [31:0] buf_data;
   logic        buf_we;

   modport master (output in_valid, in_char, input in_ready, buf_addr, buf_data, buf_we);
   modport slave  (input in_valid, in_char, output in_ready, buf_addr, buf_data, buf_we);
endinterface

// File: rtl/char_term_writer.sv
// Byte stream to character-buffer writer: cursor, wrap, line/screen clear.
// Define CHAR_TERM_SCROLL_EN to scroll through top_row; otherwise row ROWS-1 wraps to row 0.
module char_term_writer #(
   parameter int unsigned COLS   = 70,
   parameter int unsigned ROWS   = 30,
   parameter logic [11:0] FG_RST = 12'hFFF,
   parameter logic [11:0] BG_RST = 12'h000
) (
   input  logic              clk,
   input  logic              rst_n,
   char_term_writer_if.slave bus,
   input  logic              color_we,
   input  logic [23:0]       color_in,
   output logic [4:0]        top_row,
   output logic [6:0]        cur_col,
   output logic [4:0]        cur_row
);
   localparam logic [6:0] COL_LAST = 7'(COLS - 1);
   localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
   localparam logic [5:0] ROWS_W   = 6'(ROWS);

   typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_ALL} state_t;

   state_t      state, state_n;
   logic [23:0] color, color_n;
   logic [11:0] clr_cnt, cnt_n;   // {phys_row, col} of the next clear write
   logic [6:0]  col_n;
   logic [4:0]  row_n, top_n;
   logic        we_n, ready_n, adv;
   logic [11:0] addr_n;
   logic [31:0] data_n, blank;
   logic [5:0]  row_sum;
   logic [4:0]  phys_row;

   assign row_sum  = {1'b0, top_row} + {1'b0, cur_row};
   assign phys_row = (row_sum >= ROWS_W) ? 5'(row_sum - ROWS_W) : row_sum[4:0];
   assign blank    = {color, 8'h20};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         color        <= {FG_RST, BG_RST};
         clr_cnt      <= '0;
         cur_col      <= '0;
         cur_row      <= '0;
         top_row      <= '0;
         bus.in_ready <= 1'b0;
         bus.buf_we   <= 1'b0;
         bus.buf_addr <= '0;
         bus.buf_data <= '0;
      end else begin
         state        <= state_n;
         color        <= color_n;
         clr_cnt      <= cnt_n;
         cur_col      <= col_n;
         cur_row      <= row_n;
         top_row      <= top_n;
         bus.in_ready <= ready_n;
         bus.buf_we   <= we_n;
         bus.buf_addr <= addr_n;
         bus.buf_data <= data_n;
      end
   end

   always_comb begin
      state_n = state;
      color_n = color_we ? color_in : color;
      cnt_n   = clr_cnt;
      col_n   = cur_col;
      row_n   = cur_row;
      top_n   = top_row;
      we_n    = 1'b0;
      addr_n  = bus.buf_addr;
      data_n  = bus.buf_data;
      adv     = 1'b0;
      case (state)
         IDLE: if (bus.in_valid && bus.in_ready) begin
            if (bus.in_char >= 8'h20 && bus.in_char <= 8'h7E) begin
               we_n   = 1'b1;
               addr_n = {cur_col, phys_row};
               data_n = {color, bus.in_char};
               if (cur_col == COL_LAST) begin
                  col_n = '0;
                  adv   = 1'b1;
               end else begin
                  col_n = cur_col + 7'd1;
               end
            end else begin
               case (bus.in_char)
                  8'h0A: begin col_n = '0; adv = 1'b1; end
                  8'h0D: col_n = '0;
                  8'h08: if (cur_col != '0) begin
                     col_n  = cur_col - 7'd1;
                     we_n   = 1'b1;
                     addr_n = {cur_col - 7'd1, phys_row};
                     data_n = blank;
                  end
                  8'h0C: begin state_n = CLR_ALL; cnt_n = '0; end
                  default: ;
               endcase
            end
            // The row to blank is the old top_row in both builds: the new bottom after a
            // scroll, or physical row 0 when wrapping with top_row fixed at 0.
            if (adv) begin
               if (cur_row != ROW_LAST) begin
                  row_n = cur_row + 5'd1;
               end else begin
`ifdef CHAR_TERM_SCROLL_EN
                  top_n = (top_row == ROW_LAST) ? 5'd0 : top_row + 5'd1;
`else
                  row_n = '0;
`endif
                  state_n = CLR_LINE;
                  cnt_n   = {top_row, 7'd0};
               end
            end
         end
         CLR_LINE: begin
            we_n   = 1'b1;
            addr_n = {clr_cnt[6:0], clr_cnt[11:7]};
            data_n = blank;
            if (clr_cnt[6:0] == COL_LAST) state_n = IDLE;
            else                          cnt_n   = clr_cnt + 12'd1;
         end
         CLR_ALL: begin
            we_n   = 1'b1;
            addr_n = {clr_cnt[6:0], clr_cnt[11:7]};
            data_n = blank;
            if (clr_cnt[6:0] == COL_LAST) begin
               if (clr_cnt[11:7] == ROW_LAST) begin
                  state_n = IDLE;
                  top_n   = '0;
                  col_n   = '0;
                  row_n   = '0;
               end else begin
                  cnt_n = {clr_cnt[11:7] + 5'd1, 7'd0};
               end
            end else begin
               cnt_n = clr_cnt + 12'd1;
            end
         end
         default: state_n = IDLE;
      endcase
      ready_n = (state_n == IDLE);
   end
endmodule

// File: tb/tb_char_term_writer.sv
// Directed self-checking bench for char_term_writer (either CHAR_TERM_SCROLL_EN build).
module tb_char_term_writer;
`ifdef CHAR_TERM_SCROLL_EN
   localparam bit SCR = 1'b1;
`else
   localparam bit SCR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        color_we;
   logic [23:0] color_in;
   logic [4:0]  top_row, cur_row;
   logic [6:0]  cur_col;
   int          checks = 0;
   int          errors = 0;

   char_term_writer_if bus();

   char_term_writer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .color_we (color_we),
      .color_in (color_in),
      .top_row  (top_row),
      .cur_col  (cur_col),
      .cur_row  (cur_row)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] af(input int c, input int r);
      return {7'(c), 5'(r)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] ch);
      bus.in_valid = 1'b1;
      bus.in_char  = ch;
      tick();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      int drops, ce, r, c;
      logic [31:0] dexp;
      rst_n = 1'b0; bus.in_valid = 1'b0; bus.in_char = 8'h00;
      color_we = 1'b0; color_in = 24'h0;
      repeat (3) tick();
      chk("rst_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_we",    32'(bus.buf_we),   32'd0);
      chk("rst_addr",  32'(bus.buf_addr), 32'd0);
      chk("rst_data",  bus.buf_data,      32'd0);
      chk("rst_top",   32'(top_row),      32'd0);
      chk("rst_col",   32'(cur_col),      32'd0);
      chk("rst_row",   32'(cur_row),      32'd0);
      rst_n = 1'b1;
      tick();
      chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

      // "hi"
      send("h");
      chk("h_we",   32'(bus.buf_we),   32'd1);
      chk("h_addr", 32'(bus.buf_addr), 32'(af(0, 0)));
      chk("h_data", bus.buf_data,      32'hFFF00068);
      send("i");
      chk("i_addr",  32'(bus.buf_addr), 32'(af(1, 0)));
      chk("i_data",  bus.buf_data,      32'hFFF00069);
      chk("i_ready", 32'(bus.in_ready), 32'd1);
      chk("i_col",   32'(cur_col),      32'd2);
      chk("i_row",   32'(cur_row),      32'd0);
      tick();
      chk("idle_we", 32'(bus.buf_we), 32'd0);

      // colour load, then same-cycle load uses the old colour
      color_we = 1'b1; color_in = 24'h0F0FF0;
      tick();
      color_we = 1'b0;
      send("A");
      chk("A_data", bus.buf_data,      32'h0F0FF041);
      chk("A_addr", 32'(bus.buf_addr), 32'(af(2, 0)));
      color_we = 1'b1; color_in = 24'hFFF000;
      send("B");
      color_we = 1'b0;
      chk("B_data", bus.buf_data, 32'h0F0FF042);
      send("C");
      chk("C_data", bus.buf_data, 32'hFFF00043);
      chk("C_col",  32'(cur_col), 32'd5);

      // discarded byte, CR
      send(8'h01);
      chk("ign_we",  32'(bus.buf_we), 32'd0);
      chk("ign_col", 32'(cur_col),    32'd5);
      send(8'h0D);
      chk("cr_we",  32'(bus.buf_we), 32'd0);
      chk("cr_col", 32'(cur_col),    32'd0);

      // wrap across row 0
      drops = 0;
      for (int i = 0; i < 70; i++) begin
         send("x");
         if (bus.in_ready !== 1'b1) drops++;
      end
      chk("wrap_drops", 32'(drops),         32'd0);
      chk("wrap_addr",  32'(bus.buf_addr),  32'(af(69, 0)));
      chk("wrap_col",   32'(cur_col),       32'd0);
      chk("wrap_row",   32'(cur_row),       32'd1);

      // backspace
      send(8'h08);
      chk("bs0_we", 32'(bus.buf_we), 32'd0);
      send("a");
      chk("a_addr", 32'(bus.buf_addr), 32'(af(0, 1)));
      send(8'h08);
      chk("bs_we",   32'(bus.buf_we),   32'd1);
      chk("bs_addr", 32'(bus.buf_addr), 32'(af(0, 1)));
      chk("bs_data", bus.buf_data,      32'hFFF00020);
      chk("bs_col",  32'(cur_col),      32'd0);
      send(8'h08);
      chk("bs2_we", 32'(bus.buf_we), 32'd0);

      // LF down to row 29, then advance past the bottom
      repeat (28) send(8'h0A);
      chk("lf_row", 32'(cur_row), 32'd29);
      send(8'h0A);
      chk("lf_ready", 32'(bus.in_ready), 32'd0);
      chk("lf_we",    32'(bus.buf_we),   32'd0);
      chk("lf_top",   32'(top_row),      SCR ? 32'd1 : 32'd0);
      chk("lf_row2",  32'(cur_row),      SCR ? 32'd29 : 32'd0);
      bus.in_valid = 1'b1; bus.in_char = "Z";   // must be ignored while clearing
      ce = 0;
      for (int i = 0; i < 70; i++) begin
         tick();
         if (bus.buf_we !== 1'b1 || bus.buf_addr !== af(i, 0) || bus.buf_data !== 32'hFFF00020) ce++;
         if (bus.in_ready !== (i == 69)) ce++;
      end
      bus.in_valid = 1'b0;
      chk("clr_line", 32'(ce), 32'd0);
      tick();
      chk("clr_line_end_we", 32'(bus.buf_we), 32'd0);
      chk("clr_line_no_z",   32'(cur_col),    32'd0);

      // printable at (69, 29) followed by a line clear
      if (!SCR) repeat (29) send(8'h0A);
      repeat (69) send("y");
      send("z");
      chk("z_addr",  32'(bus.buf_addr), 32'(af(69, SCR ? 0 : 29)));
      chk("z_data",  bus.buf_data,      32'hFFF0007A);
      chk("z_ready", 32'(bus.in_ready), 32'd0);
      ce = 0;
      for (int i = 0; i < 70; i++) begin
         tick();
         if (bus.buf_we !== 1'b1 || bus.buf_addr !== af(i, SCR ? 1 : 0)) ce++;
         if (bus.in_ready !== (i == 69)) ce++;
      end
      chk("z_clr",  32'(ce),       32'd0);
      chk("z_top",  32'(top_row),  SCR ? 32'd2 : 32'd0);
      chk("z_row",  32'(cur_row),  SCR ? 32'd29 : 32'd0);
      chk("z_col",  32'(cur_col),  32'd0);

      // form feed with a colour change partway through
      send("q");
      send(8'h0C);
      chk("ff_ready", 32'(bus.in_ready), 32'd0);
      ce = 0;
      for (int i = 0; i < 2100; i++) begin
         tick();
         r = i / 70; c = i % 70;
         dexp = (i <= 1001) ? 32'hFFF00020 : 32'h12345620;
         if (bus.buf_we !== 1'b1 || bus.buf_addr !== af(c, r) || bus.buf_data !== dexp) ce++;
         if (bus.in_ready !== (i == 2099)) ce++;
         if (i == 1000) begin color_we = 1'b1; color_in = 24'h123456; end
         if (i == 1001) color_we = 1'b0;
      end
      chk("ff_clr", 32'(ce),      32'd0);
      chk("ff_top", 32'(top_row), 32'd0);
      chk("ff_col", 32'(cur_col), 32'd0);
      chk("ff_row", 32'(cur_row), 32'd0);
      tick();
      chk("ff_end_we", 32'(bus.buf_we), 32'd0);

      // reset in the middle of a screen clear
      send(8'h0C);
      repeat (1000) tick();
      chk("abort_pre_we", 32'(bus.buf_we), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_we",    32'(bus.buf_we),   32'd0);
      chk("abort_ready", 32'(bus.in_ready), 32'd0);
      chk("abort_addr",  32'(bus.buf_addr), 32'd0);
      tick();
      rst_n = 1'b1;
      chk("abort_ready_low", 32'(bus.in_ready), 32'd0);
      tick();
      chk("abort_ready_up", 32'(bus.in_ready), 32'd1);
      send("k");
      chk("abort_color", bus.buf_data,      32'hFFF0006B);
      chk("abort_addr2", 32'(bus.buf_addr), 32'(af(0, 0)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/char_term_writer.md
# char_term_writer

Upstream feeder of the character buffer: accepts a byte stream from the CPU/UART side over a valid/ready handshake, interprets printable and control characters, and produces write-port transactions `{fg[11:0], bg[11:0], char[7:0]}` into the 4096×32 character buffer. It maintains the cursor, line wrap, scrolling (via a circular top-row pointer exported to the display stage) and line/screen clearing. The screen is 70 columns × 30 rows, and the buffer address is `{col[6:0], phys_row[4:0]}`.

## Interface
- `COLS`, default 70: visible columns, cursor column range 0..COLS-1.
- `ROWS`, default 30: visible rows, cursor row range 0..ROWS-1.
- `FG_RST`, default 12'hFFF: reset foreground colour.
- `BG_RST`, default 12'h000: reset background colour.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk` input, 1 bit: single clock; the buffer's `wrclk` is tied to it.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: character available.
- `in_char` input, 8 bits: character byte.
- `in_ready` output, 1 bit: writer can accept a character.
- `color_we` input, 1 bit: load the colour register.
- `color_in` input, 24 bits: `{fg[11:0], bg[11:0]}`.
- `buf_addr` output, 12 bits: buffer write address `{col, phys_row}`.
- `buf_data` output, 32 bits: buffer write data `{fg, bg, char}`.
- `buf_we` output, 1 bit: buffer write enable.
- `top_row` output, 5 bits: physical row shown as screen row 0; used by the display stage.
- `cur_col` output, 7 bits: cursor column.
- `cur_row` output, 5 bits: cursor row (logical).

## Operation
- **Handshake:** a byte is accepted on a rising edge where `in_valid && in_ready`. `in_ready` is 1 only in state IDLE.
- **States:**
  - IDLE, CLR_LINE and CLR_ALL.
  - CLR_LINE and CLR_ALL use a 12-bit clear counter.
- **Physical row:** `phys_row = (top_row + cur_row) mod ROWS`. Compute it as an add followed by a conditional subtract of ROWS; no divider.
- **Printable bytes (0x20..0x7E):**
  - Write `{fg, bg, char}` at `(cur_col, phys_row)`, then `cur_col+1`.
  - At `cur_col==COLS-1` the write still occurs, then a line advance follows.
- **0x0A (LF):** `cur_col=0`, then line advance.
- **0x0D (CR):** `cur_col=0`. No write.
- **0x08 (BS):**
  - If `cur_col>0`: `cur_col-1` and write 0x20 at the new column.
  - At column 0: no action.
- **0x0C (FF):** enter CLR_ALL, writing 0x20 to every cell (col 0..69 × phys_row 0..29, 2100 writes). Then `top_row=0`, cursor (0,0), return to IDLE.
- **All other bytes:** accepted and discarded. No write, cursor unchanged.
- **Line advance:**
  - If `cur_row<ROWS-1`: `cur_row+1`.
  - Otherwise scroll: `top_row=(top_row+1) mod ROWS`, `cur_row` stays ROWS-1, and enter CLR_LINE.
- **CLR_LINE:** writes 0x20 with current colours to columns 0..69 of the new bottom physical row, then returns to IDLE.
- **Colour:** `color_we` loads the colour register in any state. A character accepted in the same cycle uses the old colour. Clear writes use the colour current at each write.
- **Reset mid-clear:** aborts the clear. Partially cleared cells stay as written.

## Timing
- **Reset values:**
  - `in_ready=0`, `buf_we=0`, `buf_addr=0`, `buf_data=0`, `top_row=0`, `cur_col=0`, `cur_row=0`.
  - Colour register = `{FG_RST, BG_RST}`.
  - `in_ready` rises on the first `clk` edge after `rst_n` deasserts.
- **Registered outputs:** all outputs are registered.
- **Write latency:** a byte accepted at edge N gives `buf_we`/`buf_addr`/`buf_data` valid during cycle N→N+1, i.e. a 1-cycle pulse.
- **Cursor update:** `cur_col`/`cur_row` update at the same edge N.
- **Back-to-back acceptance:** when no clear is triggered, `in_ready` stays 1 and a new byte can be accepted every cycle.
- **`in_ready` drop:** `in_ready` falls at the acceptance edge of any byte that triggers CLR_LINE or CLR_ALL.
- **CLR_LINE timing:**
  - `buf_we` is high for exactly COLS consecutive cycles, columns ascending from 0.
  - `in_ready` returns to 1 on the edge that issues the last write.
- **CLR_ALL timing:**
  - COLS×ROWS consecutive writes, row-major (phys_row outer, col inner).
  - `in_ready` returns to 1 with the last write.
- **Scroll on a printable byte:** a printable byte at (69, 29) with scroll writes the character first, then the COLS clear writes starting the next cycle.

## Configuration
- Macro: `CHAR_TERM_SCROLL_EN`.
- **Defined:** scrolling as described above.
- **Undefined:**
  - `top_row` is constantly 0.
  - A line advance from row ROWS-1 wraps `cur_row` to 0 and enters CLR_LINE on row 0.
  - Everything else is identical.

## Test plan
- **Reset then "hi":** reset, send "hi" → writes addr `{7'd0,5'd0}` data `{12'hFFF,12'h000,8'h68}`, then addr `{7'd1,5'd0}` 0x69. Cursor (2, 0). `in_ready` never drops.
- **Colour load:** `color_we` with 24'h0F0FF0, then 'A' → `buf_data=32'h0F0FF041`.
- **Wrap:** 70 × 'x' at row 0 → last write at col 69; cursor (0, 1); no clear.
- **Scroll:** 29 × LF, then LF → `top_row=1`, `cur_row=29`, 70 writes of 0x20 to phys_row 0 (`addr={c,5'd0}`, c=0..69), `in_ready=0` for those cycles.
- **Backspace:**
  - 'a', BS → write 0x20 at col 0, cursor col 0.
  - Second BS → no write.
- **Form feed:** FF mid-screen → 2100 writes, then `top_row=0`, cursor (0, 0).
- **Reset abort:** assert `rst_n` low at the 1000th clear write → `buf_we=0` immediately; `in_ready=1` one edge after release.
